// File: rtl/npu_addrdata_arbiter.sv
// ----------------------------------------------------------------------------
// npu_addrdata_arbiter
// Round-robin arbiter that lets NUM_M masters share one address/data slave
// port. Each grant is registered and covers exactly one write or one read
// transaction. The arbiter always returns to IDLE between grants, so the bus
// carries at most one transaction every two cycles. A per-grant watchdog
// releases the bus if the slave never completes the handshake.
//
// Ports
//   clk_i, rst_i            clock, synchronous active-high reset
//   m_w_*                   per-master write channel (packed payloads)
//   m_r_* / m_rd_ready_i    per-master read channel (packed address)
//   m_r_data_o              read data, broadcast to every master
//   s_w_* / s_r_* / s_rd_*  shared slave-side channels
//   gnt_o                   one-hot current grant, 0 when idle
//   busy_o                  a grant is active
//   timeout_o               one-cycle pulse when the watchdog fires
// ----------------------------------------------------------------------------
module npu_addrdata_arbiter #(
    parameter int NUM_M       = 4,
    parameter int TIMEOUT_CYC = 256,
    parameter int AXI_A_W     = 32,
    parameter int AXI_D_W     = 32,
    parameter int AXI_S_W     = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [NUM_M-1:0]           m_w_valid_i,
    input  logic [NUM_M*AXI_A_W-1:0]   m_w_addr_i,
    input  logic [NUM_M*AXI_D_W-1:0]   m_w_data_i,
    input  logic [NUM_M*AXI_S_W-1:0]   m_w_strb_i,
    output logic [NUM_M-1:0]           m_w_ready_o,
    input  logic [NUM_M-1:0]           m_r_valid_i,
    input  logic [NUM_M*AXI_A_W-1:0]   m_r_addr_i,
    input  logic [NUM_M-1:0]           m_rd_ready_i,
    output logic [NUM_M-1:0]           m_r_ready_o,
    output logic [AXI_D_W-1:0]         m_r_data_o,
    output logic                       s_w_valid_o,
    output logic [AXI_A_W-1:0]         s_w_addr_o,
    output logic [AXI_D_W-1:0]         s_w_data_o,
    output logic [AXI_S_W-1:0]         s_w_strb_o,
    input  logic                       s_w_ready_i,
    output logic                       s_r_valid_o,
    output logic [AXI_A_W-1:0]         s_r_addr_o,
    output logic                       s_rd_ready_o,
    input  logic                       s_r_ready_i,
    input  logic [AXI_D_W-1:0]         s_r_data_i,
    output logic [NUM_M-1:0]           gnt_o,
    output logic                       busy_o,
    output logic                       timeout_o
);

    localparam int IDX_W = (NUM_M > 1) ? $clog2(NUM_M) : 1;
    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
    localparam bit WD_EN = (TIMEOUT_CYC != 0);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WR   = 2'd1;
    localparam logic [1:0] ST_RD   = 2'd2;

    logic [1:0]        state_reg;
    logic [IDX_W-1:0]  ptr_reg;
    logic [IDX_W-1:0]  gnt_idx_reg;
    logic [CNT_W-1:0]  wd_cnt_reg;
    logic [IDX_W-1:0]  ptr_next;

    logic [NUM_M-1:0]   req;
    logic [AXI_A_W-1:0] w_addr [NUM_M];
    logic [AXI_D_W-1:0] w_data [NUM_M];
    logic [AXI_S_W-1:0] w_strb [NUM_M];
    logic [AXI_A_W-1:0] r_addr [NUM_M];

    logic              win_found;
    logic [IDX_W-1:0]  win_idx;
    logic              in_wr;
    logic              in_rd;
    logic              wr_done;
    logic              rd_done;
    logic              dropped;
    logic              wd_hit;
    logic              release_gnt;

    assign req = m_w_valid_i | m_r_valid_i;

    generate
        for (genvar gi = 0; gi < NUM_M; gi++) begin : g_unpack
            assign w_addr[gi] = m_w_addr_i[gi*AXI_A_W +: AXI_A_W];
            assign w_data[gi] = m_w_data_i[gi*AXI_D_W +: AXI_D_W];
            assign w_strb[gi] = m_w_strb_i[gi*AXI_S_W +: AXI_S_W];
            assign r_addr[gi] = m_r_addr_i[gi*AXI_A_W +: AXI_A_W];
        end
    endgenerate

    // Scan from the farthest offset back towards ptr so the requester closest
    // to ptr (in modulo order) is the last one to overwrite the winner.
    always_comb begin : p_arb
        int k;
        k         = 0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = NUM_M - 1; i >= 0; i--) begin
            k = int'(ptr_reg) + i;
            if (k >= NUM_M) begin
                k = k - NUM_M;
            end
            if (req[IDX_W'(k)]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(k);
            end
        end
    end

    assign ptr_next = (int'(gnt_idx_reg) == NUM_M - 1) ? '0 : gnt_idx_reg + IDX_W'(1);

    assign in_wr  = (state_reg == ST_WR);
    assign in_rd  = (state_reg == ST_RD);
    assign busy_o = in_wr | in_rd;

    // Slave side is a pure pass-through of the granted master, gated by state
    // so nothing leaks onto the bus while idle.
    assign s_w_valid_o  = in_wr & m_w_valid_i[gnt_idx_reg];
    assign s_w_addr_o   = in_wr ? w_addr[gnt_idx_reg] : '0;
    assign s_w_data_o   = in_wr ? w_data[gnt_idx_reg] : '0;
    assign s_w_strb_o   = in_wr ? w_strb[gnt_idx_reg] : '0;
    assign s_r_valid_o  = in_rd & m_r_valid_i[gnt_idx_reg];
    assign s_r_addr_o   = in_rd ? r_addr[gnt_idx_reg] : '0;
    assign s_rd_ready_o = in_rd & m_rd_ready_i[gnt_idx_reg];
    assign m_r_data_o   = in_rd ? s_r_data_i : '0;

    always_comb begin
        m_w_ready_o = '0;
        m_r_ready_o = '0;
        gnt_o       = '0;
        if (in_wr) begin
            m_w_ready_o[gnt_idx_reg] = s_w_ready_i;
        end
        if (in_rd) begin
            m_r_ready_o[gnt_idx_reg] = s_r_ready_i & m_rd_ready_i[gnt_idx_reg];
        end
        if (busy_o) begin
            gnt_o[gnt_idx_reg] = 1'b1;
        end
    end

    assign wr_done = s_w_valid_o & s_w_ready_i;
    assign rd_done = s_r_valid_o & s_r_ready_i & s_rd_ready_o;
    // A master withdrawing its request ends the grant quietly; this takes
    // precedence over the watchdog so no timeout is reported for it.
    assign dropped = (in_wr & ~m_w_valid_i[gnt_idx_reg]) |
                     (in_rd & ~m_r_valid_i[gnt_idx_reg]);
    assign wd_hit  = WD_EN & busy_o & (wd_cnt_reg == WD_LAST) &
                     ~wr_done & ~rd_done & ~dropped;
    assign timeout_o   = wd_hit;
    assign release_gnt = wr_done | rd_done | dropped | wd_hit;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg   <= ST_IDLE;
            ptr_reg     <= '0;
            gnt_idx_reg <= '0;
            wd_cnt_reg  <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (win_found) begin
                        gnt_idx_reg <= win_idx;
                        wd_cnt_reg  <= '0;
                        state_reg   <= m_w_valid_i[win_idx] ? ST_WR : ST_RD;
                    end
                end
                ST_WR, ST_RD: begin
                    if (release_gnt) begin
                        state_reg <= ST_IDLE;
                        ptr_reg   <= ptr_next;
                    end else begin
                        wd_cnt_reg <= wd_cnt_reg + CNT_W'(1);
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule
